// File: rtl/sand_pkg.sv
// Shared definitions for the falling-sand sweep controller.
//   CELL_EMPTY / CELL_WALL : reserved cell status codes
//   state_t                : sweep FSM state encoding
//   cell_index             : row-major cell address helper (y*w + x)
// Optional feature macro used by the users of this package: SAND_DIAG_EN.
package sand_pkg;

    localparam logic [7:0] CELL_EMPTY = 8'h00;
    localparam logic [7:0] CELL_WALL  = 8'hFF;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        RD_CUR  = 4'd1,
        CHK_CUR = 4'd2,
        RD_B    = 4'd3,
        CHK_B   = 4'd4,
        RD_L    = 4'd5,
        CHK_L   = 4'd6,
        RD_R    = 4'd7,
        CHK_R   = 4'd8,
        WR_DST  = 4'd9,
        WR_SRC  = 4'd10,
        DONE    = 4'd11
    } state_t;

    // Row-major address of cell (x,y) in a grid w cells wide.
    function automatic int cell_index(input int x, input int y, input int w);
        return (y * w) + x;
    endfunction

endpackage

// File: rtl/sand_coord_ctr.sv
// Coordinate counters and address generation for the sand sweep.
// Walks cells from (0,GRID_H-1) along each row, then up one row, ending at
// (GRID_W-1,0); advancing past the last cell reloads the start position.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   advance_i      : step to the next cell in sweep order
//   at_bottom_o    : current cell is on the bottom row
//   last_o         : current cell is the final cell of the sweep
//   at_left_o / at_right_o, addr_bl_o / addr_br_o : diagonal support
//                    (present only with SAND_DIAG_EN defined)
//   addr_cur_o     : address of current cell
//   addr_b_o       : address of the cell directly below
//   addr_nxt_o     : address of the next cell in sweep order
module sand_coord_ctr
    import sand_pkg::*;
#(
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  advance_i,
    output logic                  at_bottom_o,
    output logic                  last_o,
`ifdef SAND_DIAG_EN
    output logic                  at_left_o,
    output logic                  at_right_o,
    output logic [ADDR_WIDTH-1:0] addr_bl_o,
    output logic [ADDR_WIDTH-1:0] addr_br_o,
`endif
    output logic [ADDR_WIDTH-1:0] addr_cur_o,
    output logic [ADDR_WIDTH-1:0] addr_b_o,
    output logic [ADDR_WIDTH-1:0] addr_nxt_o
);

    localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(GRID_H - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          row_end_s;
    logic          last_s;

    // Next position in sweep order; the final cell wraps back to the start.
    always_comb begin
        row_end_s = (x_q == X_LAST);
        last_s    = row_end_s && (y_q == YW'(0));
        x_d       = x_q;
        y_d       = y_q;
        if (last_s) begin
            x_d = XW'(0);
            y_d = Y_LAST;
        end else if (row_end_s) begin
            x_d = XW'(0);
            y_d = y_q - YW'(1);
        end else begin
            x_d = x_q + XW'(1);
            y_d = y_q;
        end
    end

    // Coordinate registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q <= XW'(0);
            y_q <= Y_LAST;
        end else if (advance_i) begin
            x_q <= x_d;
            y_q <= y_d;
        end else begin
            x_q <= x_q;
            y_q <= y_q;
        end
    end

    // Neighbour addresses; out-of-grid values are never used by the FSM.
    always_comb begin
        at_bottom_o = (y_q == Y_LAST);
        last_o      = last_s;
        addr_cur_o  = ADDR_WIDTH'(cell_index(int'(x_q), int'(y_q), GRID_W));
        addr_b_o    = ADDR_WIDTH'(cell_index(int'(x_q), int'(y_q) + 1, GRID_W));
        addr_nxt_o  = ADDR_WIDTH'(cell_index(int'(x_d), int'(y_d), GRID_W));
`ifdef SAND_DIAG_EN
        at_left_o   = (x_q == XW'(0));
        at_right_o  = row_end_s;
        addr_bl_o   = ADDR_WIDTH'(cell_index(int'(x_q) - 1, int'(y_q) + 1, GRID_W));
        addr_br_o   = ADDR_WIDTH'(cell_index(int'(x_q) + 1, int'(y_q) + 1, GRID_W));
`endif
    end

endmodule

// File: rtl/sand_sweep_ctrl.sv
// Falling-sand sweep controller. One start_i pulse walks the whole grid once,
// bottom row first, moving each grain one cell down (or diagonally down when
// SAND_DIAG_EN is defined) into an empty cell via a synchronous frame RAM.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   start_i           : begin one sweep (only honoured when idle)
//   busy_o, done_o    : sweep in progress / one-cycle end-of-sweep pulse
//   rd_addr_o         : RAM read address (data returns next cycle)
//   rd_data_i         : RAM read data
//   wr_en_o, wr_addr_o, wr_data_o : RAM write port
// Configuration macro: SAND_DIAG_EN (diagonal fall; undefined = straight only).
module sand_sweep_ctrl
    import sand_pkg::*;
#(
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o
);

    localparam logic [DATA_WIDTH-1:0] D_EMPTY = DATA_WIDTH'(CELL_EMPTY);
    localparam logic [DATA_WIDTH-1:0] D_WALL  = DATA_WIDTH'(CELL_WALL);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   val_q, val_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    step_s;
    logic                    advance_s;
    logic                    at_bottom_s;
    logic                    last_s;
    logic [ADDR_WIDTH-1:0]   addr_cur_s;
    logic [ADDR_WIDTH-1:0]   addr_b_s;
    logic [ADDR_WIDTH-1:0]   addr_nxt_s;
`ifdef SAND_DIAG_EN
    logic                    at_left_s;
    logic                    at_right_s;
    logic [ADDR_WIDTH-1:0]   addr_bl_s;
    logic [ADDR_WIDTH-1:0]   addr_br_s;
`endif

    sand_coord_ctr #(
        .GRID_W     (GRID_W),
        .GRID_H     (GRID_H),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_coord (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .advance_i   (advance_s),
        .at_bottom_o (at_bottom_s),
        .last_o      (last_s),
`ifdef SAND_DIAG_EN
        .at_left_o   (at_left_s),
        .at_right_o  (at_right_s),
        .addr_bl_o   (addr_bl_s),
        .addr_br_o   (addr_br_s),
`endif
        .addr_cur_o  (addr_cur_s),
        .addr_b_o    (addr_b_s),
        .addr_nxt_o  (addr_nxt_s)
    );

    // Next state and next registered outputs. Outputs are computed for the
    // state being entered, so rd_addr_o is valid throughout each RD_* cycle.
    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        rd_addr_d = ADDR_WIDTH'(0);
        wr_en_d   = 1'b0;
        wr_addr_d = ADDR_WIDTH'(0);
        wr_data_d = DATA_WIDTH'(0);
        step_s    = 1'b0;
        advance_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RD_CUR;
                    rd_addr_d = addr_cur_s;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_CUR: state_d = CHK_CUR;
            CHK_CUR: begin
                // Bottom-row grains have nowhere to fall.
                if ((rd_data_i == D_EMPTY) || (rd_data_i == D_WALL) || at_bottom_s) begin
                    step_s = 1'b1;
                end else begin
                    val_d     = rd_data_i;
                    state_d   = RD_B;
                    rd_addr_d = addr_b_s;
                end
            end
            RD_B: state_d = CHK_B;
            CHK_B: begin
                if (rd_data_i == D_EMPTY) begin
                    state_d   = WR_DST;
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_b_s;
                    wr_data_d = val_q;
                end else begin
`ifdef SAND_DIAG_EN
                    if (!at_left_s) begin
                        state_d   = RD_L;
                        rd_addr_d = addr_bl_s;
                    end else if (!at_right_s) begin
                        state_d   = RD_R;
                        rd_addr_d = addr_br_s;
                    end else begin
                        step_s = 1'b1;
                    end
`else
                    step_s = 1'b1;
`endif
                end
            end
`ifdef SAND_DIAG_EN
            RD_L: state_d = CHK_L;
            CHK_L: begin
                if (rd_data_i == D_EMPTY) begin
                    state_d   = WR_DST;
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_bl_s;
                    wr_data_d = val_q;
                end else if (!at_right_s) begin
                    state_d   = RD_R;
                    rd_addr_d = addr_br_s;
                end else begin
                    step_s = 1'b1;
                end
            end
            RD_R: state_d = CHK_R;
            CHK_R: begin
                if (rd_data_i == D_EMPTY) begin
                    state_d   = WR_DST;
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_br_s;
                    wr_data_d = val_q;
                end else begin
                    step_s = 1'b1;
                end
            end
`endif
            WR_DST: begin
                state_d   = WR_SRC;
                wr_en_d   = 1'b1;
                wr_addr_d = addr_cur_s;
                wr_data_d = D_EMPTY;
            end
            WR_SRC: step_s = 1'b1;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Move on to the next cell, or finish after the last one.
        if (step_s) begin
            advance_s = 1'b1;
            if (last_s) begin
                state_d = DONE;
            end else begin
                state_d   = RD_CUR;
                rd_addr_d = addr_nxt_s;
            end
        end else begin
            advance_s = 1'b0;
        end

        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    // FSM state, latched grain value and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            val_q     <= DATA_WIDTH'(0);
            rd_addr_q <= ADDR_WIDTH'(0);
            wr_en_q   <= 1'b0;
            wr_addr_q <= ADDR_WIDTH'(0);
            wr_data_q <= DATA_WIDTH'(0);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rd_addr_o = rd_addr_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule
